// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard interface: operand/writer info in from the pipeline,
// stall/forward/MDU status out to the pipeline.
interface hazard_scoreboard_if #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned NSTAGE = 3,
   parameter int unsigned CNT_W  = 32
);
   localparam int unsigned SelW = $clog2(NSTAGE + 1);

   logic                     id_valid;
   logic                     id_use1;
   logic                     id_use2;
   logic                     id_is_mdu;
   logic [ADDR_W-1:0]        rs1;
   logic [ADDR_W-1:0]        rs2;
   logic [NSTAGE-1:0]        stage_wen;
   logic [NSTAGE*ADDR_W-1:0] stage_waddr;
   logic                     ex_memread;
   logic                     mdu_start;
   logic [ADDR_W-1:0]        mdu_waddr;

   logic                     stall;
   logic [SelW-1:0]          fwd1_sel;
   logic [SelW-1:0]          fwd2_sel;
   logic                     mdu_busy;
   logic                     mdu_done;
   logic                     start_err;
   logic [CNT_W-1:0]         stall_cnt;

   modport master (
      output id_valid, id_use1, id_use2, id_is_mdu, rs1, rs2, stage_wen, stage_waddr,
             ex_memread, mdu_start, mdu_waddr,
      input  stall, fwd1_sel, fwd2_sel, mdu_busy, mdu_done, start_err, stall_cnt
   );

   modport slave (
      input  id_valid, id_use1, id_use2, id_is_mdu, rs1, rs2, stage_wen, stage_waddr,
             ex_memread, mdu_start, mdu_waddr,
      output stall, fwd1_sel, fwd2_sel, mdu_busy, mdu_done, start_err, stall_cnt
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// ID-stage forwarding select, load-use / MDU stall detection, MDU busy scoreboard
// and a saturating stall-cycle counter.
module hazard_scoreboard #(
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned NSTAGE  = 3,
   parameter int unsigned MDU_LAT = 8,
   parameter int unsigned CNT_W   = 32
) (
   input logic                clk,
   input logic                rst,
   hazard_scoreboard_if.slave bus
);
   localparam int unsigned SelW = $clog2(NSTAGE + 1);
   localparam int unsigned LatW = $clog2(MDU_LAT);

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   state_e            state_q;
   logic [LatW-1:0]   cnt_q;
   logic [ADDR_W-1:0] pend_q;
   logic              start_err_q;
   logic [CNT_W-1:0]  stall_cnt_q;

   logic              busy;
   logic              done;
   logic [SelW-1:0]   sel1;
   logic [SelW-1:0]   sel2;
   logic [ADDR_W-1:0] wa0;
   logic              lu;
   logic              mr;
   logic              ms;
   logic              stall;

   assign busy = (state_q == StBusy);
   assign done = busy && (cnt_q == '0);
   assign wa0  = bus.stage_waddr[ADDR_W-1:0];

   // Walk oldest to youngest so the youngest matching stage wins.
   always_comb begin
      sel1 = '0;
      sel2 = '0;
      for (int k = int'(NSTAGE) - 1; k >= 0; k--) begin
         if (bus.stage_wen[k] && (bus.stage_waddr[k*ADDR_W +: ADDR_W] == bus.rs1)) begin
            sel1 = SelW'(k + 1);
         end
         if (bus.stage_wen[k] && (bus.stage_waddr[k*ADDR_W +: ADDR_W] == bus.rs2)) begin
            sel2 = SelW'(k + 1);
         end
      end
      if (!bus.id_valid || !bus.id_use1 || (bus.rs1 == '0)) sel1 = '0;
      if (!bus.id_valid || !bus.id_use2 || (bus.rs2 == '0)) sel2 = '0;
   end

   always_comb begin
      lu = bus.id_valid && bus.ex_memread && bus.stage_wen[0] && (wa0 != '0) &&
           ((bus.id_use1 && (bus.rs1 == wa0)) || (bus.id_use2 && (bus.rs2 == wa0)));
      mr = bus.id_valid && busy && (pend_q != '0) &&
           ((bus.id_use1 && (bus.rs1 == pend_q)) || (bus.id_use2 && (bus.rs2 == pend_q)));
      ms = bus.id_valid && bus.id_is_mdu && busy;
      stall = lu | mr | ms;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         pend_q      <= '0;
         start_err_q <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         start_err_q <= bus.mdu_start && busy;
         if (stall && bus.id_valid && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
         case (state_q)
            StIdle: begin
               if (bus.mdu_start) begin
                  state_q <= StBusy;
                  pend_q  <= bus.mdu_waddr;
                  cnt_q   <= LatW'(MDU_LAT - 1);
               end
            end
            StBusy: begin
               // A start seen here, including on the done cycle, is dropped.
               if (cnt_q == '0) begin
                  state_q <= StIdle;
               end else begin
                  cnt_q <= cnt_q - LatW'(1);
               end
            end
         endcase
      end
   end

   assign bus.stall     = stall;
   assign bus.fwd1_sel  = sel1;
   assign bus.fwd2_sel  = sel2;
   assign bus.mdu_busy  = busy;
   assign bus.mdu_done  = done;
   assign bus.start_err = start_err_q;
   assign bus.stall_cnt = stall_cnt_q;
endmodule
